// File: rtl/seg7_pkg.sv
// Shared constants, display-value struct and hex-to-segment table for the 4-digit scan controller.
// Pure declarations: no latency, no flow control.
package seg7_pkg;

    localparam int NUM_DIGITS = 4;

    localparam logic [3:0] AN_OFF  = 4'hF;
    localparam logic [6:0] SEG_OFF = 7'h7F;

    localparam logic [0:0] ST_BLANK = 1'b0;
    localparam logic [0:0] ST_ON    = 1'b1;

    typedef struct packed {
        logic [15:0] data;
        logic [3:0]  dp;
        logic [3:0]  en;
    } disp_t;

    // Active-low cathodes, bit 0 = a ... bit 6 = g; entry 15 is first in the concatenation.
    localparam logic [15:0][6:0] HEX_SEG = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/seg7_scan_controller_if.sv
// Display-value handover bundle between a value producer and the scan controller.
// Valid/ready: a value moves on any cycle where both are high.
interface seg7_scan_controller_if;

    logic        upd_valid;
    logic        upd_ready;
    logic [15:0] upd_data;
    logic [3:0]  upd_dp;
    logic [3:0]  upd_en;

    modport master (
        output upd_valid,
        output upd_data,
        output upd_dp,
        output upd_en,
        input  upd_ready
    );

    modport slave (
        input  upd_valid,
        input  upd_data,
        input  upd_dp,
        input  upd_en,
        output upd_ready
    );

endinterface

// File: rtl/seg7_hex_decoder.sv
// Nibble to active-low 7-segment pattern lookup.
// Purely combinational, zero latency, no flow control.
module seg7_hex_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/seg7_scan_controller.sv
// Time-multiplexed, blanked, PWM-dimmed scan of a 4-digit common-anode display with a double-buffered value.
// Outputs registered with no lag vs digit_sel/tick_cnt; upd_ready low while a value waits for the frame boundary.
module seg7_scan_controller
    import seg7_pkg::*;
#(
    parameter int DIGIT_TICKS = 200_000,
    parameter int BLANK_TICKS = 2_000,
    parameter int CNT_W       = 20
) (
    input  logic                   clk,
    input  logic                   rst_n,
    seg7_scan_controller_if.slave  upd,
    input  logic [3:0]             brightness,
    output logic [3:0]             an,
    output logic [6:0]             seg,
    output logic                   dp,
    output logic [1:0]             digit_sel,
    output logic                   frame_start
);

    localparam logic [CNT_W-1:0] TICK_LAST  = CNT_W'(DIGIT_TICKS - 1);
    localparam logic [CNT_W-1:0] BLANK_END  = CNT_W'(BLANK_TICKS);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [3:0]       BLANK_LO   = 4'(BLANK_TICKS);
    localparam logic [1:0]       LAST_DIGIT = 2'(NUM_DIGITS - 1);

    logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
    logic [1:0]       digit_sel_q, digit_sel_d;
    logic [0:0]       state_q, state_d;
    logic             pend_q, pend_d;
    disp_t            pend_buf_q, pend_buf_d;
    disp_t            act_q, act_d;
    logic [3:0]       bright_q, bright_d;
    logic             upd_ready_q, upd_ready_d;
    logic [3:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;
    logic             frame_start_q, frame_start_d;

    logic             wrap;
    logic             boundary;
    logic             xfer;
    logic [3:0]       phase_d;
    logic             lit_d;
    logic [3:0]       nibble_d;
    logic [6:0]       seg_dec;

    // Slot timing, handover buffering and brightness capture.
    always_comb begin
        wrap          = (tick_cnt_q == TICK_LAST);
        boundary      = wrap && (digit_sel_q == LAST_DIGIT);
        xfer          = upd.upd_valid && upd_ready_q;

        tick_cnt_d    = wrap ? '0 : tick_cnt_q + CNT_ONE;
        digit_sel_d   = wrap ? digit_sel_q + 2'd1 : digit_sel_q;
        frame_start_d = boundary;

        state_d = state_q;
        case (state_q)
            ST_BLANK: if (tick_cnt_d >= BLANK_END) state_d = ST_ON;
            ST_ON:    if (wrap && (BLANK_END != '0)) state_d = ST_BLANK;
            default:  state_d = ST_BLANK;
        endcase

        pend_d     = pend_q;
        pend_buf_d = pend_buf_q;
        act_d      = act_q;
        bright_d   = bright_q;
        if (boundary) begin
            bright_d = brightness;
            if (pend_q) begin
                act_d  = pend_buf_q;
                pend_d = 1'b0;
            end
        end
        // Ready is low whenever pend_q is set, so a capture never races the copy above.
        if (xfer) begin
            pend_d          = 1'b1;
            pend_buf_d.data = upd.upd_data;
            pend_buf_d.dp   = upd.upd_dp;
            pend_buf_d.en   = upd.upd_en;
        end
        upd_ready_d = ~pend_d;
    end

    assign nibble_d = act_d.data[{digit_sel_d, 2'b00} +: 4];

    seg7_hex_decoder u_hex_decoder (
        .nibble (nibble_d),
        .seg    (seg_dec)
    );

    // Pin values are computed from next-cycle state so they land aligned with tick_cnt/digit_sel.
    always_comb begin
        phase_d = tick_cnt_d[3:0] - BLANK_LO;
        lit_d   = (state_d == ST_ON) && (phase_d <= bright_d) && act_d.en[digit_sel_d];
        an_d    = AN_OFF;
        seg_d   = SEG_OFF;
        dp_d    = 1'b1;
        if (lit_d) begin
            an_d  = ~(4'b0001 << digit_sel_d);
            seg_d = seg_dec;
            dp_d  = ~act_d.dp[digit_sel_d];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tick_cnt_q    <= '0;
            digit_sel_q   <= 2'd0;
            state_q       <= ST_BLANK;
            pend_q        <= 1'b0;
            pend_buf_q    <= '0;
            act_q         <= '0;
            bright_q      <= 4'd0;
            upd_ready_q   <= 1'b1;
            an_q          <= AN_OFF;
            seg_q         <= SEG_OFF;
            dp_q          <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            tick_cnt_q    <= tick_cnt_d;
            digit_sel_q   <= digit_sel_d;
            state_q       <= state_d;
            pend_q        <= pend_d;
            pend_buf_q    <= pend_buf_d;
            act_q         <= act_d;
            bright_q      <= bright_d;
            upd_ready_q   <= upd_ready_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign upd.upd_ready = upd_ready_q;
    assign an            = an_q;
    assign seg           = seg_q;
    assign dp            = dp_q;
    assign digit_sel     = digit_sel_q;
    assign frame_start   = frame_start_q;

endmodule

// File: tb/tb_seg7_scan_controller.sv
// Directed bench for seg7_scan_controller with DIGIT_TICKS=8, BLANK_TICKS=2 (32-cycle frame).
module tb_seg7_scan_controller;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] brightness = 4'hF;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic [1:0] digit_sel;
    logic       frame_start;

    int checks = 0;
    int errors = 0;

    seg7_scan_controller_if u_if ();

    seg7_scan_controller #(
        .DIGIT_TICKS (8),
        .BLANK_TICKS (2),
        .CNT_W       (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .upd         (u_if),
        .brightness  (brightness),
        .an          (an),
        .seg         (seg),
        .dp          (dp),
        .digit_sel   (digit_sel),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    // Reference position and display state, advanced by the bench per clock.
    int          t;
    logic [1:0]  d;
    logic        pend;
    logic [15:0] p_data, a_data;
    logic [3:0]  p_dp, p_en, a_dp, a_en, a_bri;
    logic        last_xfer;
    logic [3:0]  exp_an;
    logic [6:0]  exp_seg;
    logic        exp_dp, exp_fs, exp_rdy;

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        case (n)
            4'h0: seg_of = 7'h40; 4'h1: seg_of = 7'h79; 4'h2: seg_of = 7'h24; 4'h3: seg_of = 7'h30;
            4'h4: seg_of = 7'h19; 4'h5: seg_of = 7'h12; 4'h6: seg_of = 7'h02; 4'h7: seg_of = 7'h78;
            4'h8: seg_of = 7'h00; 4'h9: seg_of = 7'h10; 4'hA: seg_of = 7'h08; 4'hB: seg_of = 7'h03;
            4'hC: seg_of = 7'h46; 4'hD: seg_of = 7'h21; 4'hE: seg_of = 7'h06; default: seg_of = 7'h0E;
        endcase
    endfunction

    function automatic logic [3:0] an_sel(input logic [1:0] k);
        case (k)
            2'd0:    an_sel = 4'b1110;
            2'd1:    an_sel = 4'b1101;
            2'd2:    an_sel = 4'b1011;
            default: an_sel = 4'b0111;
        endcase
    endfunction

    task automatic step();
        logic        r;
        logic        xfer;
        logic        bnd;
        logic [3:0]  bri_in;
        logic [15:0] in_data;
        logic [3:0]  in_dp, in_en;
        logic        lit;
        int          phase;
        r       = rst_n;
        xfer    = u_if.upd_valid && !pend;
        bnd     = (t == 7) && (d == 2'd3);
        bri_in  = brightness;
        in_data = u_if.upd_data;
        in_dp   = u_if.upd_dp;
        in_en   = u_if.upd_en;
        @(posedge clk);
        #1;
        last_xfer = 1'b0;
        if (!r) begin
            t = 0; d = 2'd0; pend = 1'b0; exp_fs = 1'b0;
            a_data = '0; a_dp = '0; a_en = '0; a_bri = '0;
        end else begin
            exp_fs = bnd;
            if (bnd) begin
                a_bri = bri_in;
                if (pend) begin
                    a_data = p_data; a_dp = p_dp; a_en = p_en; pend = 1'b0;
                end
            end
            if (xfer) begin
                pend = 1'b1; p_data = in_data; p_dp = in_dp; p_en = in_en; last_xfer = 1'b1;
            end
            if (t == 7) begin t = 0; d = d + 2'd1; end
            else t = t + 1;
        end
        exp_rdy = !pend;
        phase   = (t - 2) & 15;
        lit     = (t >= 2) && (phase <= int'(a_bri)) && a_en[d];
        exp_an  = lit ? an_sel(d) : 4'hF;
        exp_seg = lit ? seg_of(a_data[{d, 2'b00} +: 4]) : 7'h7F;
        exp_dp  = lit ? ~a_dp[d] : 1'b1;
    endtask

    task automatic test_reset();
        int fs_seen;
        rst_n = 1'b0;
        u_if.upd_valid = 1'b0;
        u_if.upd_data  = '0;
        u_if.upd_dp    = '0;
        u_if.upd_en    = '0;
        brightness     = 4'hF;
        repeat (3) step();
        checks++; if (an !== 4'hF)        begin errors++; $display("FAIL reset_an got %h want F", an); end
        checks++; if (seg !== 7'h7F)      begin errors++; $display("FAIL reset_seg got %h want 7F", seg); end
        checks++; if (dp !== 1'b1)        begin errors++; $display("FAIL reset_dp got %b want 1", dp); end
        checks++; if (u_if.upd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", u_if.upd_ready); end
        checks++; if (digit_sel !== 2'd0) begin errors++; $display("FAIL reset_digit_sel got %0d want 0", digit_sel); end
        checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL reset_frame_start got %b want 0", frame_start); end
        rst_n = 1'b1;
        fs_seen = 0;
        for (int i = 0; i < 32; i++) begin
            step();
            if (i < 31 && frame_start === 1'b1) fs_seen++;
            checks++;
            if ({an, seg, dp} !== {4'hF, 7'h7F, 1'b1})
                begin errors++; $display("FAIL dark_frame cyc %0d got an=%h seg=%h dp=%b want F/7F/1", i, an, seg, dp); end
            checks++;
            if (digit_sel !== d) begin errors++; $display("FAIL slot_index cyc %0d got %0d want %0d", i, digit_sel, d); end
        end
        checks++; if (fs_seen != 0) begin errors++; $display("FAIL first_frame_no_pulse got %0d pulses want 0", fs_seen); end
        checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL first_wrap_pulse got %b want 1", frame_start); end
    endtask

    task automatic test_update();
        u_if.upd_valid = 1'b1;
        u_if.upd_data  = 16'h1234;
        u_if.upd_en    = 4'hF;
        u_if.upd_dp    = 4'b0001;
        brightness     = 4'hF;
        step();
        u_if.upd_valid = 1'b0;
        for (int i = 0; i < 30; i++) begin
            checks++;
            if (u_if.upd_ready !== 1'b0 || an !== 4'hF)
                begin errors++; $display("FAIL pending_wait cyc %0d got rdy=%b an=%h want 0/F", i, u_if.upd_ready, an); end
            step();
        end
        step();
        checks++; if (u_if.upd_ready !== 1'b1) begin errors++; $display("FAIL ready_after_boundary got %b want 1", u_if.upd_ready); end
        for (int i = 0; i < 32; i++) begin
            checks++;
            if ({an, seg, dp} !== {exp_an, exp_seg, exp_dp})
                begin errors++; $display("FAIL update_frame t=%0d d=%0d got %h/%h/%b want %h/%h/%b", t, d, an, seg, dp, exp_an, exp_seg, exp_dp); end
            if (d == 2'd0 && t >= 2) begin
                checks++;
                if ({an, seg, dp} !== {4'b1110, 7'h19, 1'b0})
                    begin errors++; $display("FAIL digit0_lit t=%0d got %b/%h/%b want 1110/19/0", t, an, seg, dp); end
            end
            if (d == 2'd1 && t >= 2) begin
                checks++;
                if ({an, seg, dp} !== {4'b1101, 7'h30, 1'b1})
                    begin errors++; $display("FAIL digit1_lit t=%0d got %b/%h/%b want 1101/30/1", t, an, seg, dp); end
            end
            step();
        end
    endtask

    task automatic test_dimming();
        logic [3:0] hand_an;
        brightness = 4'd3;
        repeat (32) step();
        for (int i = 0; i < 32; i++) begin
            hand_an = (t >= 2 && t <= 5) ? an_sel(d) : 4'hF;
            checks++;
            if (an !== hand_an || seg !== exp_seg)
                begin errors++; $display("FAIL dim3 t=%0d d=%0d got an=%b seg=%h want %b/%h", t, d, an, seg, hand_an, exp_seg); end
            step();
        end
        brightness = 4'd0;
        repeat (32) step();
        for (int i = 0; i < 32; i++) begin
            hand_an = (t == 2) ? an_sel(d) : 4'hF;
            checks++;
            if (an !== hand_an || dp !== exp_dp)
                begin errors++; $display("FAIL dim0 t=%0d d=%0d got an=%b dp=%b want %b/%b", t, d, an, dp, hand_an, exp_dp); end
            step();
        end
        brightness = 4'hF;
        repeat (32) step();
    endtask

    task automatic test_enable_mask();
        int lit0, lit2;
        u_if.upd_valid = 1'b1;
        u_if.upd_data  = 16'hA5C0;
        u_if.upd_en    = 4'b0101;
        u_if.upd_dp    = 4'b0000;
        step();
        u_if.upd_valid = 1'b0;
        repeat (31) step();
        lit0 = 0;
        lit2 = 0;
        for (int i = 0; i < 128; i++) begin
            checks++;
            if (an[1] !== 1'b1 || an[3] !== 1'b1)
                begin errors++; $display("FAIL masked_digit cyc %0d got an=%b want an[1]=an[3]=1", i, an); end
            checks++;
            if ({an, seg, dp} !== {exp_an, exp_seg, exp_dp})
                begin errors++; $display("FAIL mask_frame t=%0d d=%0d got %h/%h/%b want %h/%h/%b", t, d, an, seg, dp, exp_an, exp_seg, exp_dp); end
            if (an === 4'b1110 && seg === 7'h40) lit0++;
            if (an === 4'b1011 && seg === 7'h12) lit2++;
            step();
        end
        checks++; if (lit0 != 24) begin errors++; $display("FAIL digit0_lit_count got %0d want 24", lit0); end
        checks++; if (lit2 != 24) begin errors++; $display("FAIL digit2_lit_count got %0d want 24", lit2); end
    endtask

    task automatic test_back_to_back();
        logic [6:0] shown [3];
        int fs_cnt, acc_cnt;
        shown[0] = 7'h79;
        shown[1] = 7'h24;
        shown[2] = 7'h30;
        repeat (5) step();
        u_if.upd_valid = 1'b1;
        u_if.upd_data  = 16'h1111;
        u_if.upd_en    = 4'hF;
        u_if.upd_dp    = 4'h0;
        step();
        u_if.upd_data = 16'h2222;
        fs_cnt  = 0;
        acc_cnt = 0;
        for (int i = 0; i < 96; i++) begin
            step();
            if (frame_start === 1'b1) fs_cnt++;
            if (last_xfer) begin
                acc_cnt++;
                u_if.upd_data = u_if.upd_data + 16'h1111;
            end
            checks++;
            if (u_if.upd_ready !== exp_rdy)
                begin errors++; $display("FAIL b2b_ready cyc %0d got %b want %b", i, u_if.upd_ready, exp_rdy); end
            if (fs_cnt >= 1 && fs_cnt <= 3 && d == 2'd0 && t == 2) begin
                checks++;
                if (seg !== shown[fs_cnt-1])
                    begin errors++; $display("FAIL b2b_shown frame %0d got %h want %h", fs_cnt, seg, shown[fs_cnt-1]); end
            end
        end
        u_if.upd_valid = 1'b0;
        checks++; if (fs_cnt != 3)  begin errors++; $display("FAIL frame_start_count got %0d want 3", fs_cnt); end
        checks++; if (acc_cnt != 3) begin errors++; $display("FAIL accept_count got %0d want 3", acc_cnt); end
    endtask

    task automatic test_midframe_reset();
        checks++; if (u_if.upd_ready !== 1'b0) begin errors++; $display("FAIL pending_before_reset got rdy=%b want 0", u_if.upd_ready); end
        repeat (3) step();
        rst_n = 1'b0;
        step();
        checks++;
        if ({an, seg, dp, u_if.upd_ready, digit_sel, frame_start} !== {4'hF, 7'h7F, 1'b1, 1'b1, 2'd0, 1'b0})
            begin errors++; $display("FAIL midframe_reset got an=%h seg=%h dp=%b rdy=%b ds=%0d fs=%b want F/7F/1/1/0/0",
                                     an, seg, dp, u_if.upd_ready, digit_sel, frame_start); end
        rst_n = 1'b1;
        for (int i = 0; i < 64; i++) begin
            step();
            checks++;
            if (an !== 4'hF || u_if.upd_ready !== 1'b1)
                begin errors++; $display("FAIL discarded_pending cyc %0d got an=%h rdy=%b want F/1", i, an, u_if.upd_ready); end
        end
    endtask

    initial begin
        t = 0; d = 2'd0; pend = 1'b0; last_xfer = 1'b0;
        p_data = '0; p_dp = '0; p_en = '0;
        a_data = '0; a_dp = '0; a_en = '0; a_bri = '0;
        u_if.upd_valid = 1'b0;
        test_reset();
        test_update();
        test_dimming();
        test_enable_mask();
        test_back_to_back();
        test_midframe_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
